// File: rtl/adc_rx_pkg.sv
// rtl/adc_rx_pkg.sv - shared state encoding and default training words for the ADC receiver
package adc_rx_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAIL   = 2'd3
  } adc_state_e;

  localparam logic [11:0] TRAIN_PAT_A_DEF = 12'hA5C;
  localparam logic [11:0] TRAIN_PAT_B_DEF = 12'h3C6;

endpackage

// File: rtl/adc_lane_align.sv
// rtl/adc_lane_align.sv - training FSM: settle, hunt for the test pattern, swap lanes on window expiry
module adc_lane_align
  import adc_rx_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter logic [DATA_W-1:0] TRAIN_PAT_A = DATA_W'(TRAIN_PAT_A_DEF),
  parameter logic [DATA_W-1:0] TRAIN_PAT_B = DATA_W'(TRAIN_PAT_B_DEF),
  parameter int WAIT_CYCLES = 16,
  parameter int MATCH_COUNT = 64,
  parameter int WINDOW      = 256,
  parameter int MAX_TRIES   = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              retrain,
  input  logic [DATA_W-1:0] ch1_raw,
  input  logic [DATA_W-1:0] ch2_raw,
  output logic              train_en,
  output logic              locked,
  output logic              fail,
  output logic              lane_swap
);

  localparam int WAIT_W  = $clog2(WAIT_CYCLES + 1);
  localparam int MATCH_W = $clog2(MATCH_COUNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);

  adc_state_e         state_q;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic [MATCH_W-1:0] match_cnt_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [TRY_W-1:0]   tries_q;
  logic               train_en_q;
  logic               locked_q;
  logic               fail_q;
  logic               lane_swap_q;
  logic               match;

  assign match = (ch1_raw == TRAIN_PAT_A) && (ch2_raw == TRAIN_PAT_B);

  // Each limit is acted on the cycle after its counter reaches it, so the
  // counters read as "cycles elapsed" / "matches seen" when the decision is made.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= ST_WAIT;
      wait_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      tries_q     <= '0;
      train_en_q  <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      lane_swap_q <= 1'b0;
    end else if (retrain) begin
      state_q     <= ST_WAIT;
      wait_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      tries_q     <= '0;
      train_en_q  <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (wait_cnt_q == WAIT_W'(WAIT_CYCLES)) begin
            state_q     <= ST_TRAIN;
            wait_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_TRAIN: begin
          if (match_cnt_q == MATCH_W'(MATCH_COUNT)) begin
            state_q    <= ST_LOCKED;
            tries_q    <= '0;
            train_en_q <= 1'b0;
            locked_q   <= 1'b1;
          end else if (win_cnt_q == WIN_W'(WINDOW)) begin
            lane_swap_q <= ~lane_swap_q;
            tries_q     <= tries_q + 1'b1;
            wait_cnt_q  <= '0;
            if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
              state_q    <= ST_FAIL;
              train_en_q <= 1'b0;
              fail_q     <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end else begin
            win_cnt_q   <= win_cnt_q + 1'b1;
            match_cnt_q <= match ? match_cnt_q + 1'b1 : '0;
          end
        end
        ST_LOCKED: begin
          tries_q <= '0;
        end
        ST_FAIL: begin
          fail_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_WAIT;
          train_en_q <= 1'b1;
          locked_q   <= 1'b0;
          fail_q     <= 1'b0;
        end
      endcase
    end
  end

  assign train_en  = train_en_q;
  assign locked    = locked_q;
  assign fail      = fail_q;
  assign lane_swap = lane_swap_q;

endmodule

// File: rtl/adc_ddr_capture.sv
// rtl/adc_ddr_capture.sv - two-channel DDR ADC capture: lane mapping, offset-binary conversion, alignment
// Optional sticky overrange flags are built only with ADC_RX_OVR_EN defined.
module adc_ddr_capture
  import adc_rx_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter logic [DATA_W-1:0] TRAIN_PAT_A = DATA_W'(TRAIN_PAT_A_DEF),
  parameter logic [DATA_W-1:0] TRAIN_PAT_B = DATA_W'(TRAIN_PAT_B_DEF),
  parameter int WAIT_CYCLES = 16,
  parameter int MATCH_COUNT = 64,
  parameter int WINDOW      = 256,
  parameter int MAX_TRIES   = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_rise,
  input  logic [DATA_W-1:0] adc_fall,
  input  logic              retrain,
  input  logic              ovr_clr,
  output logic [DATA_W-1:0] ch1_data,
  output logic [DATA_W-1:0] ch2_data,
  output logic              data_valid,
  output logic              train_en,
  output logic              locked,
  output logic              fail,
  output logic              lane_swap,
  output logic              ch1_ovr,
  output logic              ch2_ovr
);

  localparam logic [DATA_W-1:0] SIGN_BIT = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] rise_d, rise_q, fall_d, fall_q;
  logic [DATA_W-1:0] ch1_raw_d, ch1_raw_q, ch2_raw_d, ch2_raw_q;
  logic [DATA_W-1:0] ch1_data_d, ch1_data_q, ch2_data_d, ch2_data_q;
  logic              data_valid_d, data_valid_q;

  // Stage 2 keeps the mapped raw codes for the trainer alongside the converted outputs.
  always_comb begin
    rise_d       = adc_rise;
    fall_d       = adc_fall;
    ch1_raw_d    = lane_swap ? fall_q : rise_q;
    ch2_raw_d    = lane_swap ? rise_q : fall_q;
    data_valid_d = locked;
    ch1_data_d   = locked ? (ch1_raw_d ^ SIGN_BIT) : '0;
    ch2_data_d   = locked ? (ch2_raw_d ^ SIGN_BIT) : '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      rise_q       <= '0;
      fall_q       <= '0;
      ch1_raw_q    <= '0;
      ch2_raw_q    <= '0;
      ch1_data_q   <= '0;
      ch2_data_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      ch1_raw_q    <= ch1_raw_d;
      ch2_raw_q    <= ch2_raw_d;
      ch1_data_q   <= ch1_data_d;
      ch2_data_q   <= ch2_data_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign ch1_data   = ch1_data_q;
  assign ch2_data   = ch2_data_q;
  assign data_valid = data_valid_q;

`ifdef ADC_RX_OVR_EN
  logic ch1_ovr_d, ch1_ovr_q, ch2_ovr_d, ch2_ovr_q;

  // Flags line up with the converted sample that carried the full-scale code.
  always_comb begin
    ch1_ovr_d = ovr_clr ? 1'b0 : ch1_ovr_q;
    ch2_ovr_d = ovr_clr ? 1'b0 : ch2_ovr_q;
    if (locked && ((ch1_raw_d == '0) || (ch1_raw_d == '1))) ch1_ovr_d = 1'b1;
    if (locked && ((ch2_raw_d == '0) || (ch2_raw_d == '1))) ch2_ovr_d = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      ch1_ovr_q <= 1'b0;
      ch2_ovr_q <= 1'b0;
    end else begin
      ch1_ovr_q <= ch1_ovr_d;
      ch2_ovr_q <= ch2_ovr_d;
    end
  end

  assign ch1_ovr = ch1_ovr_q;
  assign ch2_ovr = ch2_ovr_q;
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = ovr_clr;
  assign ch1_ovr = 1'b0;
  assign ch2_ovr = 1'b0;
`endif

  adc_lane_align #(
    .DATA_W      (DATA_W),
    .TRAIN_PAT_A (TRAIN_PAT_A),
    .TRAIN_PAT_B (TRAIN_PAT_B),
    .WAIT_CYCLES (WAIT_CYCLES),
    .MATCH_COUNT (MATCH_COUNT),
    .WINDOW      (WINDOW),
    .MAX_TRIES   (MAX_TRIES)
  ) u_align (
    .clk_in    (clk_in),
    .rst       (rst),
    .retrain   (retrain),
    .ch1_raw   (ch1_raw_q),
    .ch2_raw   (ch2_raw_q),
    .train_en  (train_en),
    .locked    (locked),
    .fail      (fail),
    .lane_swap (lane_swap)
  );

endmodule

// File: tb/tb_adc_ddr_capture.sv
// tb/tb_adc_ddr_capture.sv - directed bench for adc_ddr_capture (expects flags set when ADC_RX_OVR_EN is defined)
module tb_adc_ddr_capture;

`ifdef ADC_RX_OVR_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] adc_rise = 12'h000;
  logic [11:0] adc_fall = 12'h000;
  logic        retrain = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [11:0] ch1_data, ch2_data;
  logic        data_valid, train_en, locked, fail, lane_swap, ch1_ovr, ch2_ovr;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int n;

  always #5 clk_in = ~clk_in;

  adc_ddr_capture dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .adc_rise   (adc_rise),
    .adc_fall   (adc_fall),
    .retrain    (retrain),
    .ovr_clr    (ovr_clr),
    .ch1_data   (ch1_data),
    .ch2_data   (ch2_data),
    .data_valid (data_valid),
    .train_en   (train_en),
    .locked     (locked),
    .fail       (fail),
    .lane_swap  (lane_swap),
    .ch1_ovr    (ch1_ovr),
    .ch2_ovr    (ch2_ovr)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pattern(input logic [11:0] r, input logic [11:0] f);
    adc_rise = r;
    adc_fall = f;
  endtask

  // Ends on a negedge with rst just released; the next posedge is the first active one.
  task automatic do_reset();
    @(negedge clk_in);
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
  endtask

  task automatic pulse_retrain();
    @(negedge clk_in);
    retrain = 1'b1;
    @(negedge clk_in);
    retrain = 1'b0;
  endtask

  // Returns the number of rising edges until locked (sel=0) or fail (sel=1) is seen.
  task automatic wait_for(input bit sel, input int budget, input bit rnd, output int cnt);
    bit hit;
    cnt = 0;
    hit = 1'b0;
    while (!hit && cnt < budget) begin
      @(negedge clk_in);
      cnt++;
      if (rnd) pattern(12'($urandom), 12'($urandom));
      hit = sel ? fail : locked;
    end
  endtask

  initial begin
    // Reset state, pattern present during and after reset
    pattern(12'hA5C, 12'h3C6);
    do_reset();
    check_vec("rst_locked", {31'd0, locked}, 32'd0);
    check_vec("rst_fail", {31'd0, fail}, 32'd0);
    check_vec("rst_train_en", {31'd0, train_en}, 32'd1);
    check_vec("rst_lane_swap", {31'd0, lane_swap}, 32'd0);
    check_vec("rst_valid", {31'd0, data_valid}, 32'd0);
    check_vec("rst_ch1", {20'd0, ch1_data}, 32'd0);
    check_vec("rst_ovr", {30'd0, ch1_ovr, ch2_ovr}, 32'd0);

    // Straight lane mapping: 17 wait + 64 matches + 1 decision cycle
    wait_for(1'b0, 400, 1'b0, n);
    check_vec("lock_cycles", n, 82);
    check_vec("lock_swap", {31'd0, lane_swap}, 32'd0);
    check_vec("lock_train_en", {31'd0, train_en}, 32'd0);
    check_vec("valid_lag", {31'd0, data_valid}, 32'd0);
    @(negedge clk_in);
    check_vec("lock_valid", {31'd0, data_valid}, 32'd1);
    check_vec("lock_ch1", {20'd0, ch1_data}, 32'h25C);
    check_vec("lock_ch2", {20'd0, ch2_data}, 32'hBC6);
    check_vec("lock_ovr", {30'd0, ch1_ovr, ch2_ovr}, 32'd0);

    // Full-scale codes: 2-cycle latency, sticky overrange
    pattern(12'h000, 12'hFFF);
    @(negedge clk_in);
    check_vec("fs_ch1_lat1", {20'd0, ch1_data}, 32'h25C);
    @(negedge clk_in);
    check_vec("fs_ch1", {20'd0, ch1_data}, 32'h800);
    check_vec("fs_ch2", {20'd0, ch2_data}, 32'h7FF);
    check_vec("fs_ovr", {30'd0, ch1_ovr, ch2_ovr}, {30'd0, OVR_EXP, OVR_EXP});
    pattern(12'hA5C, 12'h3C6);
    repeat (2) @(negedge clk_in);
    check_vec("ovr_sticky", {30'd0, ch1_ovr, ch2_ovr}, {30'd0, OVR_EXP, OVR_EXP});
    check_vec("ovr_ch1_back", {20'd0, ch1_data}, 32'h25C);
    ovr_clr = 1'b1;
    @(negedge clk_in);
    ovr_clr = 1'b0;
    check_vec("ovr_clr", {30'd0, ch1_ovr, ch2_ovr}, 32'd0);
    // Set beats clear on the same cycle; CH2 sees only the clear
    pattern(12'h000, 12'h3C6);
    ovr_clr = 1'b1;
    repeat (2) @(negedge clk_in);
    check_vec("ovr_set_wins", {30'd0, ch1_ovr, ch2_ovr}, {30'd0, OVR_EXP, 1'b0});
    ovr_clr = 1'b0;
    pattern(12'hA5C, 12'h3C6);

    // Reset mid-TRAIN after 40 matches: needs a full fresh sequence
    do_reset();
    repeat (57) @(negedge clk_in);
    check_vec("mid_train_locked", {31'd0, locked}, 32'd0);
    check_vec("mid_train_en", {31'd0, train_en}, 32'd1);
    do_reset();
    wait_for(1'b0, 400, 1'b0, n);
    check_vec("relock_cycles", n, 82);

    // Swapped lanes: first window expires, then lock with lane_swap=1
    pattern(12'h3C6, 12'hA5C);
    do_reset();
    wait_for(1'b0, 1000, 1'b0, n);
    check_vec("swap_lock_cycles", n, 356);
    check_vec("swap_lane", {31'd0, lane_swap}, 32'd1);
    @(negedge clk_in);
    check_vec("swap_ch1", {20'd0, ch1_data}, 32'h25C);
    check_vec("swap_ch2", {20'd0, ch2_data}, 32'hBC6);
    pulse_retrain();
    check_vec("rt_locked", {31'd0, locked}, 32'd0);
    check_vec("rt_train_en", {31'd0, train_en}, 32'd1);
    check_vec("rt_keep_swap", {31'd0, lane_swap}, 32'd1);
    wait_for(1'b0, 400, 1'b0, n);
    check_vec("rt_lock_cycles", n, 82);

    // Random data: four windows then FAIL; retrain clears tries
    do_reset();
    wait_for(1'b1, 3000, 1'b1, n);
    check_vec("fail_cycles", n, 1096);
    check_vec("fail_locked", {31'd0, locked}, 32'd0);
    check_vec("fail_train_en", {31'd0, train_en}, 32'd0);
    repeat (3) @(negedge clk_in);
    check_vec("fail_hold", {31'd0, fail}, 32'd1);
    check_vec("fail_valid", {31'd0, data_valid}, 32'd0);
    check_vec("fail_ch1_zero", {20'd0, ch1_data}, 32'd0);
    pulse_retrain();
    check_vec("fail_rt_fail", {31'd0, fail}, 32'd0);
    check_vec("fail_rt_train_en", {31'd0, train_en}, 32'd1);
    wait_for(1'b1, 3000, 1'b1, n);
    check_vec("refail_cycles", n, 1096);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
